// File: rtl/app_ui_pkg.sv
// Shared types and constants for the app_ui responder (DDR3 user-interface stand-in).
// The optional ready-throttling LFSR is enabled by APP_UI_RANDOM_STALL_EN in the top.
package app_ui_pkg;

    localparam int APP_ADDR_W = 28;
    localparam int APP_DATA_W = 128;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef struct packed {
        logic [APP_ADDR_W-1:0] addr;
        logic [2:0]            cmd;
    } app_cmd_t;

    // x^16 + x^14 + x^13 + x^11 + 1, shift-left Fibonacci form
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/app_ui_responder_if.sv
// app_* command / write-data / read-data bundle between a UI initiator and the responder.
interface app_ui_responder_if
    import app_ui_pkg::*;
#(
    parameter int ADDR_W = APP_ADDR_W,
    parameter int DATA_W = APP_DATA_W
);
    // Handshake: a command moves on a clock edge where app_en & app_rdy, a write beat where
    // app_wdf_wren & app_wdf_rdy; ready never depends on en/wren in the same cycle. Read
    // data has no ready: app_rd_data is consumed on every cycle app_rd_data_valid is high.
    logic [ADDR_W-1:0]   app_addr;
    logic [2:0]          app_cmd;
    logic                app_en;
    logic                app_rdy;
    logic [DATA_W-1:0]   app_wdf_data;
    logic [DATA_W/8-1:0] app_wdf_mask;
    logic                app_wdf_wren;
    logic                app_wdf_end;
    logic                app_wdf_rdy;
    logic [DATA_W-1:0]   app_rd_data;
    logic                app_rd_data_valid;
    logic                app_rd_data_end;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );

endinterface

// File: rtl/app_ui_fifo.sv
// Small synchronous FIFO with registered occupancy count; head is visible combinationally.
module app_ui_fifo
    import app_ui_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (count != CNT_W'(DEPTH));
    assign do_pop   = pop && (count != '0);
    assign pop_data = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/app_ui_responder.sv
// Block-RAM backed responder for the DDR3 app_* user interface with fixed read latency.
// Optional: define APP_UI_RANDOM_STALL_EN to throttle app_rdy/app_wdf_rdy from an LFSR.
module app_ui_responder
    import app_ui_pkg::*;
#(
    parameter int ADDR_W         = APP_ADDR_W,
    parameter int DATA_W         = APP_DATA_W,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int RD_LATENCY     = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int CALIB_CYCLES   = 64
) (
    input  logic                clk,
    input  logic                sys_rst,
    app_ui_responder_if.slave   ui,
    output logic                init_calib_complete,
    output logic                proto_err
);

    localparam int MASK_W    = DATA_W / 8;
    localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int CALIB_W   = $clog2(CALIB_CYCLES + 1);
    localparam int CMD_W     = $bits(app_cmd_t);

    // ---------------- calibration ----------------
    logic [CALIB_W-1:0] calib_cnt;
    logic               calib_done;

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            calib_cnt  <= '0;
            calib_done <= 1'b0;
        end else if (!calib_done) begin
            if (calib_cnt == CALIB_W'(CALIB_CYCLES - 1)) begin
                calib_done <= 1'b1;
            end else begin
                calib_cnt <= calib_cnt + 1'b1;
            end
        end
    end

    assign init_calib_complete = calib_done;

    // ---------------- optional ready throttling ----------------
    logic cmd_stall;
    logic wdf_stall;

`ifdef APP_UI_RANDOM_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign cmd_stall = lfsr[0];
    assign wdf_stall = lfsr[1];
`else
    assign cmd_stall = 1'b0;
    assign wdf_stall = 1'b0;
`endif

    // ---------------- command and write-data FIFOs ----------------
    app_cmd_t                  cmd_in;
    app_cmd_t                  cmd_head;
    logic [CMD_W-1:0]          cmd_head_bits;
    logic [CNT_W-1:0]          cmd_count;
    logic [MASK_W+DATA_W-1:0]  wdf_head_bits;
    logic [CNT_W-1:0]          wdf_count;
    logic                      cmd_rdy;
    logic                      wdf_rdy;
    logic                      cmd_push;
    logic                      wdf_push;
    logic                      cmd_pop;
    logic                      wdf_pop;

    // Readiness comes only from registered state, so a full FIFO never accepts on a pop cycle.
    assign cmd_rdy = calib_done && (cmd_count < CNT_W'(FIFO_DEPTH)) && !cmd_stall;
    assign wdf_rdy = calib_done && (wdf_count < CNT_W'(FIFO_DEPTH)) && !wdf_stall;
    assign ui.app_rdy     = cmd_rdy;
    assign ui.app_wdf_rdy = wdf_rdy;

    assign cmd_push = ui.app_en && cmd_rdy;
    assign wdf_push = ui.app_wdf_wren && wdf_rdy;
    assign cmd_in   = '{addr: APP_ADDR_W'(ui.app_addr), cmd: ui.app_cmd};
    assign cmd_head = app_cmd_t'(cmd_head_bits);

    app_ui_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (sys_rst),
        .push      (cmd_push),
        .push_data (cmd_in),
        .pop       (cmd_pop),
        .pop_data  (cmd_head_bits),
        .count     (cmd_count)
    );

    app_ui_fifo #(.WIDTH(MASK_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_wdf_fifo (
        .clk       (clk),
        .rst_n     (sys_rst),
        .push      (wdf_push),
        .push_data ({ui.app_wdf_mask, ui.app_wdf_data}),
        .pop       (wdf_pop),
        .pop_data  (wdf_head_bits),
        .count     (wdf_count)
    );

    // ---------------- executor ----------------
    logic                      head_valid;
    logic                      exec_rd;
    logic                      exec_wr;
    logic                      exec_bad;
    logic [MEM_DEPTH_LOG2-1:0] mem_idx;
    logic [DATA_W-1:0]         wr_data;
    logic [MASK_W-1:0]         wr_mask;
    logic                      unused_addr_bits;

    assign head_valid = (cmd_count != '0);
    assign exec_rd    = head_valid && (cmd_head.cmd == CMD_READ);
    // A write with no beat waiting blocks the head, and with it every later command.
    assign exec_wr    = head_valid && (cmd_head.cmd == CMD_WRITE) && (wdf_count != '0);
    assign exec_bad   = head_valid && (cmd_head.cmd != CMD_READ) && (cmd_head.cmd != CMD_WRITE);
    assign cmd_pop    = exec_rd || exec_wr || exec_bad;
    assign wdf_pop    = exec_wr;

    // Addresses count 16-bit units, so a 128-bit beat spans 8 of them; high bits alias.
    assign mem_idx          = cmd_head.addr[3 +: MEM_DEPTH_LOG2];
    assign unused_addr_bits = ^{cmd_head.addr[2:0], cmd_head.addr[APP_ADDR_W-1:MEM_DEPTH_LOG2+3]};
    assign {wr_mask, wr_data} = wdf_head_bits;

    // ---------------- memory ----------------
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (exec_wr) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!wr_mask[b]) begin
                    mem[mem_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- read return pipeline ----------------
    logic [RD_LATENCY-1:0] rd_vld;
    logic [DATA_W-1:0]     rd_pipe [RD_LATENCY];

    // Each data stage loads only alongside its valid, so the last stage holds between pulses.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rd_vld <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                rd_pipe[k] <= '0;
            end
        end else begin
            rd_vld[0] <= exec_rd;
            if (exec_rd) begin
                rd_pipe[0] <= mem[mem_idx];
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                rd_vld[k] <= rd_vld[k-1];
                if (rd_vld[k-1]) begin
                    rd_pipe[k] <= rd_pipe[k-1];
                end
            end
        end
    end

    assign ui.app_rd_data       = rd_pipe[RD_LATENCY-1];
    assign ui.app_rd_data_valid = rd_vld[RD_LATENCY-1];
    assign ui.app_rd_data_end   = rd_vld[RD_LATENCY-1];

    // ---------------- protocol error flag ----------------
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            proto_err <= 1'b0;
        end else if ((ui.app_en && !calib_done) ||
                     (ui.app_wdf_wren && !calib_done) ||
                     (ui.app_wdf_wren && !ui.app_wdf_end) ||
                     exec_bad) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_app_ui_responder.sv
// Directed + randomized bench for app_ui_responder against a queue-based memory model.
module tb_app_ui_responder;
  import app_ui_pkg::*;

  localparam logic [127:0] D_RT     = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] MASK_EXP = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  logic init_calib_complete;
  logic proto_err;

  always #5 clk = ~clk;

  app_ui_responder_if #(.ADDR_W(28), .DATA_W(128)) ui ();

  app_ui_responder dut (
    .clk                 (clk),
    .sys_rst             (sys_rst),
    .ui                  (ui),
    .init_calib_complete (init_calib_complete),
    .proto_err           (proto_err)
  );

  // ---------------- reference model ----------------
  typedef struct { logic [2:0] cmd; int idx; } op_t;
  typedef struct { logic [127:0] data; logic [15:0] mask; } beat_t;

  op_t          ops[$];
  beat_t        beats[$];
  logic [127:0] exp_q[$];
  logic [127:0] mem_m [1024];

  int n_checks = 0;
  int n_fail = 0;
  int pulse_count = 0;
  int cur_run = 0;
  int last_run_len = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Commands resolve strictly in issue order; a write waits until some beat is available.
  task automatic model_step();
    while (ops.size() != 0) begin
      if (ops[0].cmd == CMD_READ) begin
        exp_q.push_back(mem_m[ops[0].idx]);
        void'(ops.pop_front());
      end else if (ops[0].cmd == CMD_WRITE) begin
        if (beats.size() == 0) break;
        for (int b = 0; b < 16; b++)
          if (!beats[0].mask[b]) mem_m[ops[0].idx][b*8 +: 8] = beats[0].data[b*8 +: 8];
        void'(ops.pop_front());
        void'(beats.pop_front());
      end else begin
        void'(ops.pop_front());
      end
    end
  endtask

  function automatic int addr_to_idx(input logic [27:0] a);
    return int'(a[12:3]);
  endfunction

  function automatic logic [27:0] mk_addr(input int idx);
    logic [2:0] hi = 3'($urandom_range(0, 7));
    logic [2:0] lo = 3'($urandom_range(0, 7));
    return {12'd0, hi, 10'(idx), lo};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks (entered just after a falling edge) ----------------
  task automatic send_cmd(input logic [2:0] cmd, input logic [27:0] addr);
    int waits = 0;
    op_t op;
    op.cmd = cmd;
    op.idx = addr_to_idx(addr);
    ops.push_back(op);
    model_step();
    ui.app_cmd  = cmd;
    ui.app_addr = addr;
    ui.app_en   = 1'b1;
    while (!ui.app_rdy && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 300) chk("cmd_accept_timeout", 1'b0, 1'b1);
    @(negedge clk);
    ui.app_en = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] data, input logic [15:0] mask);
    int waits = 0;
    beat_t bt;
    bt.data = data;
    bt.mask = mask;
    beats.push_back(bt);
    model_step();
    ui.app_wdf_data = data;
    ui.app_wdf_mask = mask;
    ui.app_wdf_wren = 1'b1;
    while (!ui.app_wdf_rdy && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 300) chk("beat_accept_timeout", 1'b0, 1'b1);
    @(negedge clk);
    ui.app_wdf_wren = 1'b0;
  endtask

  task automatic send_write(input logic [27:0] addr, input logic [127:0] data, input logic [15:0] mask);
    int   waits = 0;
    logic c_pend = 1'b1;
    logic w_pend = 1'b1;
    logic c_acc;
    logic w_acc;
    op_t   op;
    beat_t bt;
    op.cmd = CMD_WRITE;
    op.idx = addr_to_idx(addr);
    bt.data = data;
    bt.mask = mask;
    ops.push_back(op);
    beats.push_back(bt);
    model_step();
    ui.app_cmd = CMD_WRITE;
    ui.app_addr = addr;
    ui.app_en = 1'b1;
    ui.app_wdf_data = data;
    ui.app_wdf_mask = mask;
    ui.app_wdf_wren = 1'b1;
    while ((c_pend || w_pend) && waits < 300) begin
      c_acc = c_pend && ui.app_rdy;
      w_acc = w_pend && ui.app_wdf_rdy;
      @(negedge clk);
      waits++;
      if (c_acc) begin c_pend = 1'b0; ui.app_en = 1'b0; end
      if (w_acc) begin w_pend = 1'b0; ui.app_wdf_wren = 1'b0; end
    end
    if (c_pend || w_pend) begin
      chk("write_accept_timeout", 1'b0, 1'b1);
      ui.app_en = 1'b0;
      ui.app_wdf_wren = 1'b0;
    end
  endtask

  task automatic drain();
    int waits = 0;
    while ((exp_q.size() != 0 || ops.size() != 0) && waits < 500) begin
      @(negedge clk);
      waits++;
    end
    chk("drain_done", 1'(exp_q.size() == 0 && ops.size() == 0), 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_calib();
    int waits = 0;
    while (!init_calib_complete && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    chk("recal_done", init_calib_complete, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p0;
    int lat;
    logic [127:0] d_a, d_b;
    logic [127:0] stall_d [4];
    int stream_idx [10] = '{0, 1, 2, 8, 9, 10, 11, 0, 1, 2};

    ui.app_addr = '0; ui.app_cmd = '0; ui.app_en = 1'b0;
    ui.app_wdf_data = '0; ui.app_wdf_mask = '0; ui.app_wdf_wren = 1'b0; ui.app_wdf_end = 1'b1;

    // scoreboard for the read return port
    fork
      forever begin
        @(negedge clk);
        if (ui.app_rd_data_valid === 1'b1) begin
          pulse_count++;
          cur_run++;
          chk("rd_end", ui.app_rd_data_end, 1'b1);
          if (exp_q.size() == 0) chk("unexpected_rd_valid", 1'b1, 1'b0);
          else chk("rd_data", ui.app_rd_data, exp_q.pop_front());
        end else if (cur_run != 0) begin
          last_run_len = cur_run;
          cur_run = 0;
        end
      end
    join_none

    // reset values, then calibration window
    #1 sys_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_calib", init_calib_complete, 1'b0);
    chk("rst_rdy", {ui.app_rdy, ui.app_wdf_rdy}, 2'b00);
    chk("rst_rd_valid", {ui.app_rd_data_valid, ui.app_rd_data_end}, 2'b00);
    chk("rst_rd_data", ui.app_rd_data, 128'd0);
    chk("rst_proto_err", proto_err, 1'b0);
    sys_rst = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk);
      #1;
      if (c < 64) chk("calib_low", {init_calib_complete, ui.app_rdy, ui.app_wdf_rdy}, 3'b000);
      else        chk("calib_high", {init_calib_complete, ui.app_rdy, ui.app_wdf_rdy}, 3'b111);
    end
    @(negedge clk);

    // write/read round trip and latency
    send_write(28'h008, D_RT, 16'h0);
    p0 = pulse_count;
    send_cmd(CMD_READ, 28'h008);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (lat == 0 && ui.app_rd_data_valid === 1'b1) begin
        lat = i;
        chk("rt_data", ui.app_rd_data, D_RT);
      end
    end
    chk("rt_latency", 128'(lat), 128'd4);
    chk("rt_one_pulse", 128'(pulse_count - p0), 128'd1);

    // byte mask
    send_write(28'h010, {128{1'b1}}, 16'h0);
    send_write(28'h010, 128'd0, 16'h00FF);
    send_cmd(CMD_READ, 28'h010);
    drain();
    chk("mask_data_hold", ui.app_rd_data, MASK_EXP);

    // write commands without data stall the queue
    for (int i = 0; i < 4; i++) send_cmd(CMD_WRITE, 28'(32'h040 + 8 * i));
    chk("stall_rdy_low", ui.app_rdy, 1'b0);
    repeat (3) @(negedge clk);
    chk("stall_still_low", {ui.app_rdy, ui.app_wdf_rdy}, 2'b01);
    for (int i = 0; i < 4; i++) begin
      stall_d[i] = rnd128();
      send_beat(stall_d[i], 16'h0);
    end
    repeat (3) @(negedge clk);
    chk("stall_rdy_back", ui.app_rdy, 1'b1);
    for (int i = 0; i < 4; i++) send_cmd(CMD_READ, 28'(32'h040 + 8 * i));
    drain();
    chk("stall_last_data", ui.app_rd_data, stall_d[3]);
    chk("stall_run", 128'(last_run_len), 128'd4);

    // index aliasing and streaming reads
    d_a = rnd128();
    d_b = rnd128();
    send_write(28'h0000, d_a, 16'h0);
    send_write(28'h2000, d_b, 16'h0);
    send_cmd(CMD_READ, 28'h0000);
    drain();
    chk("alias_data", ui.app_rd_data, d_b);
    p0 = pulse_count;
    for (int i = 0; i < 10; i++) send_cmd(CMD_READ, 28'(stream_idx[i] * 8));
    drain();
    chk("stream_pulses", 128'(pulse_count - p0), 128'd10);
    chk("stream_run", 128'(last_run_len), 128'd10);

    // undefined command code
    p0 = pulse_count;
    send_cmd(3'b010, 28'h008);
    repeat (10) @(negedge clk);
    chk("bad_cmd_err", proto_err, 1'b1);
    chk("bad_cmd_no_rd", 128'(pulse_count - p0), 128'd0);

    // reset with reads in flight; memory must survive
    send_cmd(CMD_READ, 28'h008);
    send_cmd(CMD_READ, 28'h010);
    sys_rst = 1'b0;
    ops.delete();
    beats.delete();
    exp_q.delete();
    p0 = pulse_count;
    repeat (8) @(negedge clk);
    chk("midrst_no_rd", 128'(pulse_count - p0), 128'd0);
    chk("midrst_err_clr", proto_err, 1'b0);
    chk("midrst_outs", {init_calib_complete, ui.app_rdy, ui.app_wdf_rdy, ui.app_rd_data_valid}, 4'b0000);
    chk("midrst_rd_data", ui.app_rd_data, 128'd0);
    sys_rst = 1'b1;
    wait_calib();
    send_cmd(CMD_READ, 28'h008);
    send_cmd(CMD_READ, 28'h010);
    drain();
    chk("retained_data", ui.app_rd_data, MASK_EXP);

    // randomized traffic over a small prefilled window
    for (int i = 0; i < 16; i++) send_write(mk_addr(i), rnd128(), 16'h0);
    for (int n = 0; n < 40; n++) begin
      int kind = $urandom_range(0, 3);
      int idx = $urandom_range(0, 15);
      if (kind < 2) begin
        send_cmd(CMD_READ, mk_addr(idx));
      end else if (kind == 2) begin
        send_write(mk_addr(idx), rnd128(), 16'($urandom));
      end else if ($urandom_range(0, 1) == 1) begin
        send_beat(rnd128(), 16'($urandom));
        send_cmd(CMD_WRITE, mk_addr(idx));
      end else begin
        send_cmd(CMD_WRITE, mk_addr(idx));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_beat(rnd128(), 16'($urandom));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // beat without wdf_end is still written but flags an error
    chk("pre_end_err", proto_err, 1'b0);
    d_a = rnd128();
    ui.app_wdf_end = 1'b0;
    send_write(28'h0300, d_a, 16'h0);
    ui.app_wdf_end = 1'b1;
    send_cmd(CMD_READ, 28'h0300);
    drain();
    chk("no_end_err", proto_err, 1'b1);
    chk("no_end_data", ui.app_rd_data, d_a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/app_ui_responder.md
Name: app_ui_responder

Overview:
- Responder end of the DDR3 controller user interface (app_* command/write-data/read-data handshake). It stands in for the MIG core in simulation and in no-DDR builds.
- Backs a block-RAM array of 128-bit beats and produces the calibration, ready, and read-return behaviour that the frame writer and VGA line reader drive against.
- One command per cycle, executed in order, with a fixed read latency.

Parameters:
- ADDR_W, 28, app_addr width.
- DATA_W, 128, beat width; mask width is DATA_W/8.
- MEM_DEPTH_LOG2, 10, log2 of the number of stored beats.
- RD_LATENCY, 4, cycles from command execution to app_rd_data_valid (minimum 1).
- FIFO_DEPTH, 4, entries in each of the command FIFO and the write-data FIFO.
- CALIB_CYCLES, 64, cycles after reset release before init_calib_complete rises.

Ports:
- clk  in  1  single clock; stands in for ui_clk.
- sys_rst  in  1  asynchronous, active-low reset.
- app_addr  in  ADDR_W  command address in 16-bit units.
- app_cmd  in  3  000 = write, 001 = read.
- app_en  in  1  command valid.
- app_rdy  out  1  command accept.
- app_wdf_data  in  DATA_W  write beat.
- app_wdf_mask  in  DATA_W/8  1 = byte not written.
- app_wdf_wren  in  1  write data valid.
- app_wdf_end  in  1  last beat; must be 1.
- app_wdf_rdy  out  1  write data accept.
- app_rd_data  out  DATA_W  read beat.
- app_rd_data_valid  out  1  read beat valid.
- app_rd_data_end  out  1  equals app_rd_data_valid.
- init_calib_complete  out  1  calibration done.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (sys_rst=0, async):
  - all outputs 0, including app_rd_data.
  - FIFOs, read pipeline, and calibration counter cleared.
  - memory contents NOT cleared.
- Reset mid-operation: queued and in-flight commands are dropped, and the calibration count restarts.
- Calibration: counter runs CALIB_CYCLES cycles after reset release, then init_calib_complete=1 and stays 1.
- Ready signals (combinational from registered counts; no same-cycle bypass when full):
  - app_rdy = calib & (cmd_count < FIFO_DEPTH).
  - app_wdf_rdy = calib & (wdf_count < FIFO_DEPTH).
- Accepts:
  - Command accepted on a rising edge where app_en & app_rdy.
  - Write beat accepted where app_wdf_wren & app_wdf_rdy.
  - A command and a write beat may be accepted in the same cycle.
  - Write data may precede or follow its command by any number of cycles.
- Address mapping:
  - word index = app_addr[3 +: MEM_DEPTH_LOG2].
  - app_addr[2:0] ignored; higher bits ignored (wrap-around aliasing).
- Executor: one FIFO head per cycle.
  - Read: memory read issued; data enters a RD_LATENCY-deep valid/data pipeline.
  - Write: executes only when the write-data FIFO is non-empty. It pops both FIFOs and writes the unmasked bytes. With the write-data FIFO empty, the head stalls and all later commands wait.
  - Other app_cmd codes: popped and discarded, and proto_err set.
- Read return:
  - app_rd_data_valid is a one-cycle pulse per read, RD_LATENCY cycles after execution, in command order.
  - No backpressure on read data.
  - app_rd_data holds its last value while valid is 0.
- Ordering: commands execute in order, so a read after a write to the same index returns the new data, including the back-to-back case.
- Back-to-back: sustained 1 command per cycle when the FIFOs are not stalled.
- Protocol errors (each sets proto_err; the cycle is otherwise still handled):
  - app_wdf_wren with app_wdf_end=0: beat still accepted.
  - app_en or app_wdf_wren while init_calib_complete=0: ignored.
- proto_err clears only on reset.

Optional Feature:
- Macro APP_UI_RANDOM_STALL_EN.
- Defined:
  - A 16-bit LFSR (seed 16'hACE1, reset to seed) advances every cycle.
  - When lfsr[0]=1, app_rdy is forced low; when lfsr[1]=1, app_wdf_rdy is forced low.
  - Data and ordering are unchanged; this exercises initiator retry paths.
- Undefined: ready depends only on calibration and FIFO occupancy.

Decomposition:
- Package app_ui_pkg holds:
  - CMD_WRITE=3'b000, CMD_READ=3'b001.
  - Default ADDR_W and DATA_W.
  - The app_ui command struct typedef {addr, cmd}.
- Sub-module app_ui_fifo (parameterized width and depth, count output) is instantiated twice: command FIFO and write-data FIFO (data+mask).
- Memory array, executor, and read pipeline stay in the top.

Test Plan:
- Calibration: release sys_rst → init_calib_complete, app_rdy, and app_wdf_rdy stay 0 for 64 cycles, then read 1.
- Write/read round trip: write addr 0x008, data 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, mask 0; read addr 0x008 next cycle → one valid pulse 4 cycles after execution with identical data; app_rd_data_end=1 in the same cycle.
- Mask: prefill 0x010 with all-ones, then write zeros with mask 16'h00FF → readback 128'h0000…0000_FFFF_FFFF_FFFF_FFFF (upper 8 bytes zero).
- Stall/backpressure: issue 4 write commands with no write data → app_rdy=0 after the 4th; supply 4 beats → all 4 written in order; app_rdy returns to 1.
- Aliasing/streaming: writes to 0x0000 then 0x2000 (index wrap at 1024 beats); read 0x0000 → returns the 0x2000 data. 10 back-to-back reads → 10 consecutive valid pulses.
- Error and reset: app_cmd=3'b010 → proto_err=1, no read return. Assert sys_rst with 2 reads in flight → no valid pulses; proto_err=0; earlier written data still readable after recalibration.
